// File: rtl/jt49_pkg.sv
// Shared constants for the JT49 clock-enable generators: mode encodings and
// default log2 tap divisions.
package jt49_pkg;

    typedef enum logic [1:0] {
        JT49_DIV1 = 2'd0,
        JT49_DIV2 = 2'd1,
        JT49_DIV4 = 2'd2,
        JT49_DIV8 = 2'd3
    } jt49_mode_e;

    localparam int JT49_DIVA_DEF = 3;
    localparam int JT49_DIVB_DEF = 7;

endpackage

// File: rtl/jt49_cen_frac_if.sv
// Control/strobe bundle of jt49_cen_frac: upstream enable, ratio, mode in;
// base and tap strobes out.
interface jt49_cen_frac_if #(
    parameter int W = 16
);
    logic         cen;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [1:0]   mode;
    logic         cen_base;
    logic         cen_a;
    logic         cen_b;

    modport master (output cen, num, den, mode, input cen_base, cen_a, cen_b);
    modport slave  (input cen, num, den, mode, output cen_base, cen_a, cen_b);
endinterface

// File: rtl/jt49_cen_acc.sv
// Fractional num/den phase accumulator; only built when JT49_CEN_FRAC_EN is
// defined. base is combinational and already qualified by cen.
module jt49_cen_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         base
);
    logic [W-1:0] acc_reg, acc_next;
    logic [W:0]   sum;
    logic         sat;

    always_comb begin
        sum      = {1'b0, acc_reg} + {1'b0, num};
        sat      = (den == '0) || (num >= den);
        acc_next = acc_reg;
        base     = 1'b0;
        if (cen) begin
            if (sat) begin
                acc_next = '0;
                base     = 1'b1;
            end else if (sum >= {1'b0, den}) begin
                // num < den here, so the difference always fits in W bits
                acc_next = W'(sum - {1'b0, den});
                base     = 1'b1;
            end else begin
                acc_next = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_reg <= '0;
        else     acc_reg <= acc_next;
    end
endmodule

// File: rtl/jt49_cen_frac.sv
// Clock-enable generator: optional fractional base (JT49_CEN_FRAC_EN) feeding a
// free-running prescaler with two power-of-two taps and a wrap-aligned mode latch.
import jt49_pkg::*;

module jt49_cen_frac #(
    parameter int W    = 16,
    parameter int CW   = 10,
    parameter int DIVA = JT49_DIVA_DEF,
    parameter int DIVB = JT49_DIVB_DEF
) (
    input  logic           clk,
    input  logic           rst,
    jt49_cen_frac_if.slave bus
);
    logic          base;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    sh_reg;
    logic          base_reg;
    logic [1:0]    tap_reg;
    logic [1:0]    tap_hit;

    if (DIVA + 3 > CW || DIVB + 3 > CW) begin : g_bad_cfg
        $fatal(1, "jt49_cen_frac: DIVA+3 and DIVB+3 must not exceed CW");
    end

`ifdef JT49_CEN_FRAC_EN
    jt49_cen_acc #(.W(W)) u_acc (
        .clk  (clk),
        .rst  (rst),
        .cen  (bus.cen),
        .num  (bus.num),
        .den  (bus.den),
        .base (base)
    );
`else
    assign base = bus.cen;
`endif

    // Taps compare the pre-increment count so the first base pulse hits both
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tap
            localparam int DIV = (gi == 0) ? DIVA : DIVB;
            logic [CW-1:0] mask;
            assign mask        = ~({CW{1'b1}} << (DIV + int'(sh_reg)));
            assign tap_hit[gi] = (cnt_reg & mask) == '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            sh_reg   <= '0;
            base_reg <= 1'b0;
            tap_reg  <= '0;
        end else begin
            base_reg <= base;
            tap_reg  <= {2{base}} & tap_hit;
            if (base) begin
                cnt_reg <= cnt_reg + CW'(1);
                // Latching only at cnt==0 keeps every emitted period whole
                if (cnt_reg == '0) sh_reg <= bus.mode;
            end
        end
    end

    assign bus.cen_base = base_reg;
    assign bus.cen_a    = tap_reg[0];
    assign bus.cen_b    = tap_reg[1];
endmodule
